// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sequencer state encoding for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_NRD   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of read, write, reserve and clear signals for regfile_sb.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned NRD   = DEF_NRD
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_busy, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_busy, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-producer busy bits: set on reserve, released on write, wiped on clear.
// REGFILE_BYPASS_EN forwards a same-cycle write's release onto rd_busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned NRD   = DEF_NRD,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rsv_fire,
    input  logic [AW-1:0]          rsv_addr,
    input  logic                   rel_fire,
    input  logic [AW-1:0]          rel_addr,
    input  logic                   clr_all,
    input  logic [NRD-1:0][AW-1:0] rd_addr,
    output logic [NRD-1:0]         rd_busy
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Reserve is applied after release so a same-cycle pair leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (rel_fire) busy_d[rel_addr] = 1'b0;
        if (rsv_fire) busy_d[rsv_addr] = 1'b1;
        if (clr_all)  busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            if (rel_fire && rd_addr[i] == rel_addr) begin
                rd_busy[i] = rsv_fire && (rsv_addr == rel_addr);
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with scoreboard and sequential clear; r0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy onto the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned NRD   = DEF_NRD,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic is_idle;
    logic wr_fire;
    logic rsv_fire;
    logic clr_start;

    assign is_idle   = (state_q == StIdle);
    assign wr_fire   = is_idle && bus.wr_en && (bus.wr_addr != '0);
    assign rsv_fire  = is_idle && bus.rsv_en && (bus.rsv_addr != '0);
    assign clr_start = is_idle && bus.clr_req;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        case (state_q)
            StIdle: begin
                if (wr_fire) regs_d[bus.wr_addr] = bus.wr_data;
                if (clr_start) begin
                    state_d = StClear;
                    idx_d   = AW'(1);
                end
            end
            StClear: begin
                regs_d[idx_q] = '0;
                // Hold the index at the top entry so it never wraps within a sequence.
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_addr[i] != '0) rd_data[i] = regs_q[bus.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && bus.rd_addr[i] == bus.wr_addr) rd_data[i] = bus.wr_data;
`endif
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_fire (rsv_fire),
        .rsv_addr (bus.rsv_addr),
        .rel_fire (wr_fire),
        .rel_addr (bus.wr_addr),
        .clr_all  (clr_start),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (rd_busy)
    );

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.clr_busy = (state_q != StIdle);
    assign bus.clr_done = (state_q == StDone);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: per-cycle model comparison plus directed literal checks.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register array, busy flags and a clear phase (0 idle, 1..NREGS active).
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];
    int              m_phase;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (bus.wr_en && bus.wr_addr != 0) begin
                m_regs[bus.wr_addr] <= bus.wr_data;
                m_busy[bus.wr_addr] <= 1'b0;
            end
            if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] <= 1'b1;
            if (bus.clr_req) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] <= 1'b0;
                m_phase <= 1;
            end
        end else if (m_phase < NREGS) begin
            m_regs[m_phase] <= '0;
            m_phase <= m_phase + 1;
        end else begin
            m_phase <= 0;
        end
    end

    function automatic logic wr_accepted();
        return rst_n && m_phase == 0 && bus.wr_en && bus.wr_addr != 0;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (wr_accepted() && a == bus.wr_addr) return bus.wr_data;
`endif
        return (a == 0) ? '0 : m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (wr_accepted() && a == bus.wr_addr) return bus.rsv_en && bus.rsv_addr == bus.wr_addr;
`endif
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    always @(negedge clk) begin
        for (int p = 0; p < NRD; p++) begin
            check("cmp rd_data", bus.rd_data[p], exp_data(bus.rd_addr[p]));
            check("cmp rd_busy", bus.rd_busy[p], exp_busy(bus.rd_addr[p]));
        end
        check("cmp clr_busy", bus.clr_busy, m_phase != 0);
        check("cmp clr_done", bus.clr_done, m_phase == NREGS);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = a;
        cyc();
        bus.rsv_en = 1'b0;
    endtask

    // Combinational sweep of every register; set times stay odd to avoid the compare edge.
    task automatic sweep_zero(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            bus.rd_addr[0] = AW'(a);
            bus.rd_addr[1] = AW'(a);
            #1;
            check({tag, " data"}, bus.rd_data[0], 0);
            check({tag, " busy"}, bus.rd_busy[1], 0);
            #1;
        end
    endtask

    int busy_cnt, done_cnt, done_at;

    initial begin
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.clr_req  = 1'b0;
        bus.rd_addr[0] = 5'd5;
        #3;
        check("reset clr_busy", bus.clr_busy, 0);
        check("reset clr_done", bus.clr_done, 0);
        check("reset rd_data", bus.rd_data[0], 0);
        check("reset rd_busy", bus.rd_busy[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic write/read and hardwired r0.
        wr(5'd5, 32'hDEADBEEF);
        bus.rd_addr[0] = 5'd5;
        smp();
        check("r5 readback", bus.rd_data[0], 32'hDEADBEEF);
        cyc();
        wr(5'd0, 32'h1234);
        bus.rd_addr[0] = 5'd0;
        smp();
        check("r0 reads zero", bus.rd_data[0], 0);
        cyc();

        // Same-cycle write visibility on port 1.
        wr(5'd7, 32'h11111111);
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'hA5A5A5A5;
        bus.rd_addr[1] = 5'd7;
        smp();
`ifdef REGFILE_BYPASS_EN
        check("r7 bypass", bus.rd_data[1], 32'hA5A5A5A5);
`else
        check("r7 no bypass", bus.rd_data[1], 32'h11111111);
`endif
        cyc();
        bus.wr_en = 1'b0;
        smp();
        check("r7 after edge", bus.rd_data[1], 32'hA5A5A5A5);
        cyc();

        // Scoreboard reserve/release and reserve-wins.
        rsv(5'd3);
        bus.rd_addr[0] = 5'd3;
        smp();
        check("r3 reserved", bus.rd_busy[0], 1);
        cyc();
        wr(5'd3, 32'h33);
        smp();
        check("r3 released", bus.rd_busy[0], 0);
        cyc();
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd3;
        wr(5'd3, 32'h3333);
        bus.rsv_en = 1'b0;
        smp();
        check("r3 rsv wins busy", bus.rd_busy[0], 1);
        check("r3 rsv wins data", bus.rd_data[0], 32'h3333);
        rsv(5'd0);
        bus.rd_addr[1] = 5'd0;
        smp();
        check("r0 never busy", bus.rd_busy[1], 0);
        cyc();

        // Full clear sequence with a dropped write mid-way.
        for (int i = 1; i < NREGS; i++) wr(AW'(i), XLEN'(i));
        rsv(5'd4);
        rsv(5'd9);
        bus.rd_addr[0] = 5'd20;
        bus.rd_addr[1] = 5'd3;
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 40; k++) begin
            smp();
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 5) begin
                check("mid-clear r20 intact", bus.rd_data[0], 20);
                check("mid-clear r3 cleared", bus.rd_data[1], 0);
            end
            if (k == 10) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 5'd2;
                bus.wr_data = 32'hFFFF;
                bus.rsv_en = 1'b1;
                bus.rsv_addr = 5'd6;
            end
            if (k == 11) begin
                bus.wr_en = 1'b0;
                bus.rsv_en = 1'b0;
            end
        end
        check("clear busy cycles", busy_cnt, 32);
        check("clear done cycle", done_at, 32);
        check("clear done pulses", done_cnt, 1);
        sweep_zero("post-clear");
        cyc();

        // Reset during a clear sequence aborts it.
        for (int i = 1; i < NREGS; i++) wr(AW'(i), XLEN'(i + 100));
        bus.rd_addr[0] = 5'd20;
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        repeat (5) smp();
        check("pre-reset clr_busy", bus.clr_busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort clr_busy", bus.clr_busy, 0);
        check("abort clr_done", bus.clr_done, 0);
        check("abort r20", bus.rd_data[0], 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            smp();
            if (bus.clr_done) done_cnt++;
            if (bus.clr_busy) busy_cnt++;
        end
        check("abort no done", done_cnt, 0);
        check("abort stays idle", busy_cnt, 0);
        sweep_zero("post-abort");
        cyc();

        wr(5'd31, 32'hCAFEF00D);
        bus.rd_addr[1] = 5'd31;
        smp();
        check("r31 after reset", bus.rd_data[1], 32'hCAFEF00D);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of 2, >=4); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of asynchronous read ports (1..4).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rd_addr  input  NRD x AW  read addresses, port i in slice i.
REQ-007 rd_data  output  NRD x XLEN  read data per port.
REQ-008 rd_busy  output  NRD  scoreboard busy bit of each addressed register.
REQ-009 wr_en  input  1  write strobe.
REQ-010 wr_addr  input  AW  write address.
REQ-011 wr_data  input  XLEN  write data.
REQ-012 rsv_en  input  1  reserve (mark pending producer) strobe.
REQ-013 rsv_addr  input  AW  register to reserve.
REQ-014 clr_req  input  1  request sequential clear of all registers.
REQ-015 clr_busy  output  1  high while a clear sequence runs.
REQ-016 clr_done  output  1  one-cycle pulse when a clear sequence finishes.

Function
REQ-017 rd_data[i] SHALL be combinational from rd_addr[i]; register 0 SHALL always read 0.
REQ-018 Write: on a rising edge with wr_en=1, wr_addr!=0, state IDLE -> reg[wr_addr] <= wr_data; otherwise no change.
REQ-019 Scoreboard: busy[rsv_addr] set on an edge with rsv_en=1, rsv_addr!=0, state IDLE; busy[wr_addr] cleared on every accepted write.
REQ-020 Same-cycle reserve and write to the same register SHALL leave busy=1 (reserve wins) and still store wr_data.
REQ-021 busy[0] SHALL be constant 0; rsv_en to register 0 ignored.
REQ-022 Clear FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on clr_req=1; CLEAR zeroes one register per cycle, index 1 to NREGS-1 ascending; CLEAR->DONE after index NREGS-1 written; DONE->IDLE unconditionally.
REQ-023 Entering CLEAR SHALL clear all busy bits on the same edge; clear latency from clr_req edge to clr_done pulse = NREGS cycles.
REQ-024 clr_busy=1 in CLEAR and DONE; clr_done=1 only in DONE.
REQ-025 In CLEAR/DONE, wr_en and rsv_en SHALL be ignored (dropped, not queued); clr_req ignored outside IDLE.
REQ-026 Reads during CLEAR SHALL return current array contents (partly cleared).
REQ-027 Index counter SHALL be AW bits and SHALL NOT wrap to 0 within a sequence.

Reset
REQ-028 rst_n=0 SHALL asynchronously zero all registers, all busy bits and the index counter, force state IDLE; clr_busy=0, clr_done=0.
REQ-029 Reset asserted mid-clear SHALL abort the sequence with no clr_done pulse.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0, state IDLE and rd_addr[i]==wr_addr, rd_data[i]=wr_data and rd_busy[i]=0 unless rsv_en=1 with rsv_addr==wr_addr (then 1).
REQ-031 Macro undefined: rd_data and rd_busy SHALL reflect stored state only; written value visible the cycle after the write.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state enum and parameter defaults (XLEN, NREGS, NRD).
REQ-033 Sub-module regfile_scoreboard SHALL own busy bits, reserve/release/clear logic and rd_busy lookup.

Verification
REQ-034 Write 0xDEADBEEF to r5, read r5 next cycle on port 0 -> 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-035 Bypass build: write 0xA5A5A5A5 to r7 with rd_addr[1]=7 same cycle -> rd_data[1]=0xA5A5A5A5; non-bypass build -> old value.
REQ-036 Reserve r3, next cycle rd_busy=1; write r3 -> busy 0 after edge; reserve+write r3 same cycle -> busy 1, data stored.
REQ-037 Fill r1..r31 with index value, pulse clr_req -> clr_busy high 32 cycles, clr_done at cycle 32, all registers 0, all busy 0, write attempted at cycle 10 dropped.
REQ-038 Drop rst_n at cycle 5 of clear -> outputs 0 immediately, no clr_done, all registers 0.
